calc_sequencer: RTL and testbench

Top-level calculation sequencer for the 16-bit signed calculator. It consumes decoded key events from the keypad input controller over the `read_input`/`key_read` handshake and builds signed decimal operands A and B. It issues one operation at a time to the external arithmetic unit over a start/done handshake and drives the value and error flag shown on the display.

---
 rtl/calc_sequencer_if.sv | 37 +++
 rtl/calc_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_sequencer_if.sv
// Signal bundle between the calculator sequencer and its neighbours:
// keypad controller handshake, arithmetic unit start/done handshake and
// the display outputs. The sequencer uses the master side.
interface calc_sequencer_if;
  // keypad controller
  logic               read_input;
  logic               key_read;
  logic [3:0]         keypad_input;
  logic [2:0]         operator_input;
  logic               equal_input;
  // arithmetic unit
  logic               alu_start;
  logic [1:0]         alu_op;
  logic signed [15:0] alu_a;
  logic signed [15:0] alu_b;
  logic               alu_done;
  logic signed [15:0] alu_result;
  logic               alu_ovf;
  // display / status
  logic signed [15:0] disp_value;
  logic               disp_error;
  logic               busy;

  modport master (
    input  read_input, keypad_input, operator_input, equal_input,
    input  alu_done, alu_result, alu_ovf,
    output key_read, alu_start, alu_op, alu_a, alu_b,
    output disp_value, disp_error, busy
  );

  modport slave (
    output read_input, keypad_input, operator_input, equal_input,
    output alu_done, alu_result, alu_ovf,
    input  key_read, alu_start, alu_op, alu_a, alu_b,
    input  disp_value, disp_error, busy
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculation sequencer for the 16-bit signed calculator.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ENTER_A     | building first operand A from digit/sign keys
// ENTER_B     | building second operand B; op latched
// EXEC        | one-cycle alu_start with A, B, op
// WAIT_ALU    | waiting for alu_done, timeout down-counter running
// SHOW_RESULT | result held in A and displayed
// ERROR       | overflow/timeout/negate fault; next key clears everything
module calc_sequencer #(
  parameter int ALU_TIMEOUT = 64
) (
  input logic                clk,
  input logic                nRST,
  calc_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    ENTER_A, ENTER_B, EXEC, WAIT_ALU, SHOW_RESULT, ERROR
  } state_t;

  state_t             state;
  logic signed [15:0] a_reg;
  logic signed [15:0] b_reg;
  logic [14:0]        mag;
  logic               sign_neg;
  logic               dig_flag;
  logic [1:0]         op;
  logic [1:0]         pend_op;
  logic               chain;
  logic [15:0]        tmo_cnt;
  logic               armed;

  logic               accept;
  logic               is_eq;
  logic               is_sign;
  logic               is_arith;
  logic               is_digit;
  logic [1:0]         key_op;
  logic [19:0]        new_mag;
  logic               digit_ok;
  logic signed [15:0] operand;
  logic               a_is_min;

  // A key is taken only while not talking to the ALU, and only once per press.
  assign accept   = armed & bus.read_input &
                    (state inside {ENTER_A, ENTER_B, SHOW_RESULT, ERROR});
  assign is_eq    = bus.equal_input;
  assign is_sign  = !bus.equal_input && (bus.operator_input == 3'b001);
  assign is_arith = !bus.equal_input &&
                    (bus.operator_input inside {3'b010, 3'b011, 3'b100});
  assign is_digit = !bus.equal_input && (bus.operator_input == 3'b000);
  assign key_op   = (bus.operator_input == 3'b010) ? 2'b00 :
                    (bus.operator_input == 3'b011) ? 2'b01 : 2'b10;
  assign new_mag  = 20'(mag) * 20'd10 + 20'(bus.keypad_input);
  assign digit_ok = (new_mag <= 20'd32767);
  assign operand  = sign_neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  assign a_is_min = (a_reg == 16'sh8000);

  // Sequencer FSM with registered handshake, ALU and display outputs.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state          <= ENTER_A;
      a_reg          <= '0;
      b_reg          <= '0;
      mag            <= '0;
      sign_neg       <= 1'b0;
      dig_flag       <= 1'b0;
      op             <= '0;
      pend_op        <= '0;
      chain          <= 1'b0;
      tmo_cnt        <= '0;
      armed          <= 1'b1;
      bus.key_read   <= 1'b0;
      bus.alu_start  <= 1'b0;
      bus.alu_op     <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.disp_value <= '0;
      bus.disp_error <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.key_read  <= 1'b0;
      bus.alu_start <= 1'b0;
      if (!bus.read_input) armed <= 1'b1;
      if (accept) begin
        bus.key_read <= 1'b1;
        armed        <= 1'b0;
      end

      // display follows the registers one cycle later; result/error paths override below
      case (state)
        ENTER_A, ENTER_B: bus.disp_value <= operand;
        SHOW_RESULT:      bus.disp_value <= a_reg;
        ERROR:            bus.disp_value <= '0;
        default:          ;
      endcase

      case (state)
        ENTER_A, ENTER_B: begin
          if (accept) begin
            if (is_digit) begin
              if (digit_ok) begin
                mag      <= new_mag[14:0];
                dig_flag <= 1'b1;
              end
            end else if (is_sign) begin
              sign_neg <= ~sign_neg;
            end else if (is_arith) begin
              if (state == ENTER_A) begin
                op       <= key_op;
                a_reg    <= operand;
                mag      <= '0;
                sign_neg <= 1'b0;
                dig_flag <= 1'b0;
                state    <= ENTER_B;
              end else if (!dig_flag) begin
                op <= key_op;
              end else begin
                pend_op  <= key_op;
                chain    <= 1'b1;
                b_reg    <= operand;
                state    <= EXEC;
                bus.busy <= 1'b1;
              end
            end else if (is_eq && (state == ENTER_B)) begin
              b_reg    <= operand;
              state    <= EXEC;
              bus.busy <= 1'b1;
            end
          end
        end

        EXEC: begin
          bus.alu_start <= 1'b1;
          bus.alu_a     <= a_reg;
          bus.alu_b     <= b_reg;
          bus.alu_op    <= op;
          tmo_cnt       <= 16'(ALU_TIMEOUT - 1);
          state         <= WAIT_ALU;
        end

        WAIT_ALU: begin
          if (bus.alu_done) begin
            bus.busy <= 1'b0;
            if (bus.alu_ovf) begin
              state          <= ERROR;
              bus.disp_error <= 1'b1;
              bus.disp_value <= '0;
            end else begin
              a_reg          <= bus.alu_result;
              bus.disp_value <= bus.alu_result;
              if (chain) begin
                op       <= pend_op;
                chain    <= 1'b0;
                mag      <= '0;
                sign_neg <= 1'b0;
                dig_flag <= 1'b0;
                state    <= ENTER_B;
              end else begin
                state <= SHOW_RESULT;
              end
            end
          end else if (tmo_cnt == '0) begin
            bus.busy       <= 1'b0;
            state          <= ERROR;
            bus.disp_error <= 1'b1;
            bus.disp_value <= '0;
          end else begin
            tmo_cnt <= tmo_cnt - 16'd1;
          end
        end

        SHOW_RESULT: begin
          if (accept) begin
            if (is_digit) begin
              a_reg    <= '0;
              b_reg    <= '0;
              op       <= '0;
              pend_op  <= '0;
              chain    <= 1'b0;
              sign_neg <= 1'b0;
              mag      <= 15'(bus.keypad_input);
              dig_flag <= 1'b1;
              state    <= ENTER_A;
            end else if (is_sign) begin
              if (a_is_min) begin
                state          <= ERROR;
                bus.disp_error <= 1'b1;
                bus.disp_value <= '0;
              end else begin
                a_reg <= -a_reg;
              end
            end else if (is_arith) begin
              op       <= key_op;
              mag      <= '0;
              sign_neg <= 1'b0;
              dig_flag <= 1'b0;
              state    <= ENTER_B;
            end
          end
        end

        ERROR: begin
          // the clearing key is swallowed, not applied
          if (accept) begin
            a_reg          <= '0;
            b_reg          <= '0;
            mag            <= '0;
            sign_neg       <= 1'b0;
            dig_flag       <= 1'b0;
            op             <= '0;
            pend_op        <= '0;
            chain          <= 1'b0;
            tmo_cnt        <= '0;
            bus.disp_error <= 1'b0;
            bus.disp_value <= '0;
            state          <= ENTER_A;
          end
        end

        default: state <= ENTER_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: keypad stimulus, an ALU responder with random
// latency, and a plain-arithmetic calculator model for expected values.
module tb_calc_sequencer;
  logic clk = 1'b0;
  logic nRST;

  calc_sequencer_if bus();

  calc_sequencer #(.ALU_TIMEOUT(64)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int cap_a = 0;
  int cap_b = 0;
  int cap_op = 0;
  bit silent = 1'b0;
  int late_req = 0;
  int kr_pulses = 0;

  function automatic int alu_model(input int a, input int b, input int op);
    if (op == 0) return a + b;
    if (op == 1) return a - b;
    return a * b;
  endfunction

  function automatic bit out_of_range(input int r);
    return (r > 32767) || (r < -32768);
  endfunction

  // ALU responder: captures each request, answers after 0..4 cycles
  initial begin
    int lat;
    bit pend;
    int r;
    int late_seen;
    lat = 0; pend = 0; r = 0; late_seen = 0;
    bus.alu_done = 1'b0; bus.alu_result = '0; bus.alu_ovf = 1'b0;
    forever begin
      @(negedge clk);
      bus.alu_done = 1'b0;
      bus.alu_ovf  = 1'b0;
      if (bus.alu_start === 1'b1) begin
        start_cnt++;
        cap_a  = int'(bus.alu_a);
        cap_b  = int'(bus.alu_b);
        cap_op = int'(bus.alu_op);
        if (!silent) begin
          r    = alu_model(cap_a, cap_b, cap_op);
          pend = 1'b1;
          lat  = int'($urandom_range(0, 4));
        end
      end
      if (pend) begin
        if (lat == 0) begin
          bus.alu_done   = 1'b1;
          bus.alu_result = 16'(r);
          bus.alu_ovf    = out_of_range(r);
          pend = 1'b0;
        end else begin
          lat--;
        end
      end
      if (late_req != late_seen) begin
        late_seen      = late_req;
        bus.alu_done   = 1'b1;
        bus.alu_result = 16'sd1234;
        bus.alu_ovf    = 1'b0;
      end
    end
  end

  // key_read pulse counter
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.key_read === 1'b1 && !prev) kr_pulses++;
      prev = bus.key_read;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    bus.read_input = 1'b0; bus.keypad_input = '0;
    bus.operator_input = '0; bus.equal_input = 1'b0;
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
  endtask

  // kind 0 = digit, 1 = operator code, 2 = equals. Ends one cycle after the ack.
  task automatic press(input int kind, input int val, output bit start_next);
    bit acked;
    acked = 1'b0;
    bus.keypad_input   = (kind == 0) ? 4'(val) : 4'd0;
    bus.operator_input = (kind == 1) ? 3'(val) : 3'd0;
    bus.equal_input    = (kind == 2);
    bus.read_input     = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.key_read === 1'b1) begin acked = 1'b1; break; end
    end
    bus.read_input = 1'b0;
    checks++;
    if (!acked) begin
      errors++;
      $display("FAIL key_ack: no key_read within 300 cycles (kind=%0d val=%0d)", kind, val);
    end
    @(negedge clk);
    start_next = bus.alu_start;
  endtask

  task automatic key_digit(input int d);
    bit s; press(0, d, s);
  endtask
  task automatic key_op(input int code);
    bit s; press(1, code, s);
  endtask
  task automatic key_eq();
    bit s; press(2, 0, s);
  endtask

  task automatic enter_num(input int v);
    string s;
    s = $sformatf("%0d", (v < 0) ? -v : v);
    for (int i = 0; i < s.len(); i++) key_digit(int'(s[i]) - 48);
    if (v < 0) key_op(1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_drop: busy still high after 200 cycles");
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.key_read, bus.alu_start, bus.busy, bus.disp_error} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000",
                         {bus.key_read, bus.alu_start, bus.busy, bus.disp_error});
    end
    checks++;
    if (bus.disp_value !== 16'sd0) begin
      errors++; $display("FAIL reset_disp: got %0d want 0", bus.disp_value);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 34'b0) begin
      errors++; $display("FAIL reset_alu: a=%0d b=%0d op=%0d want 0", bus.alu_a, bus.alu_b, bus.alu_op);
    end
  endtask

  task automatic test_basic_add();
    int kr0, sc0;
    bit sn;
    apply_reset();
    kr0 = kr_pulses; sc0 = start_cnt;
    key_digit(1);
    checks++;
    if (bus.disp_value !== 16'sd1) begin errors++; $display("FAIL add_disp1: got %0d want 1", bus.disp_value); end
    key_digit(2);
    checks++;
    if (bus.disp_value !== 16'sd12) begin errors++; $display("FAIL add_disp12: got %0d want 12", bus.disp_value); end
    key_op(2);
    key_digit(3); key_digit(4);
    checks++;
    if (bus.disp_value !== 16'sd34) begin errors++; $display("FAIL add_disp34: got %0d want 34", bus.disp_value); end
    press(2, 0, sn);
    checks++;
    if (sn !== 1'b1) begin errors++; $display("FAIL add_start_timing: alu_start=%0b want 1", sn); end
    wait_idle();
    @(negedge clk);
    checks++;
    if (cap_a != 12 || cap_b != 34 || cap_op != 0) begin
      errors++; $display("FAIL add_req: a=%0d b=%0d op=%0d want 12 34 0", cap_a, cap_b, cap_op);
    end
    checks++;
    if (start_cnt - sc0 != 1) begin errors++; $display("FAIL add_starts: got %0d want 1", start_cnt - sc0); end
    checks++;
    if (bus.disp_value !== 16'sd46 || bus.disp_error !== 1'b0) begin
      errors++; $display("FAIL add_result: disp=%0d err=%0b want 46 0", bus.disp_value, bus.disp_error);
    end
    checks++;
    if (kr_pulses - kr0 != 6) begin errors++; $display("FAIL add_acks: got %0d want 6", kr_pulses - kr0); end
  endtask

  task automatic test_saturate();
    int kr0, sc0;
    apply_reset();
    kr0 = kr_pulses; sc0 = start_cnt;
    key_digit(3); key_digit(2); key_digit(7); key_digit(6); key_digit(7);
    checks++;
    if (bus.disp_value !== 16'sd32767) begin errors++; $display("FAIL sat_max: got %0d want 32767", bus.disp_value); end
    key_digit(9);
    checks++;
    if (bus.disp_value !== 16'sd32767) begin errors++; $display("FAIL sat_ignore: got %0d want 32767", bus.disp_value); end
    checks++;
    if (kr_pulses - kr0 != 6) begin errors++; $display("FAIL sat_acks: got %0d want 6", kr_pulses - kr0); end
    key_eq();
    checks++;
    if (bus.busy !== 1'b0 || start_cnt != sc0 || bus.disp_value !== 16'sd32767) begin
      errors++; $display("FAIL eq_in_a: busy=%0b starts=%0d disp=%0d want 0 0 32767",
                         bus.busy, start_cnt - sc0, bus.disp_value);
    end
    apply_reset();
    key_digit(3); key_digit(2); key_digit(7); key_digit(6); key_digit(8);
    checks++;
    if (bus.disp_value !== 16'sd3276) begin errors++; $display("FAIL sat_32768: got %0d want 3276", bus.disp_value); end
  endtask

  task automatic test_sign_mul();
    apply_reset();
    key_op(1); key_digit(5);
    checks++;
    if (bus.disp_value !== -16'sd5) begin errors++; $display("FAIL sign_a: got %0d want -5", bus.disp_value); end
    key_op(4); key_digit(3); key_op(1);
    checks++;
    if (bus.disp_value !== -16'sd3) begin errors++; $display("FAIL sign_b: got %0d want -3", bus.disp_value); end
    key_eq();
    wait_idle();
    @(negedge clk);
    checks++;
    if (cap_a != -5 || cap_b != -3 || cap_op != 2) begin
      errors++; $display("FAIL mul_req: a=%0d b=%0d op=%0d want -5 -3 2", cap_a, cap_b, cap_op);
    end
    checks++;
    if (bus.disp_value !== 16'sd15) begin errors++; $display("FAIL mul_result: got %0d want 15", bus.disp_value); end
  endtask

  task automatic test_op_replace();
    apply_reset();
    key_digit(6); key_op(2); key_op(4); key_digit(7); key_eq();
    wait_idle();
    @(negedge clk);
    checks++;
    if (cap_op != 2 || bus.disp_value !== 16'sd42) begin
      errors++; $display("FAIL op_replace: op=%0d disp=%0d want 2 42", cap_op, bus.disp_value);
    end
  endtask

  task automatic test_chain();
    bit sn;
    apply_reset();
    key_digit(7); key_op(2); key_digit(2);
    press(1, 3, sn);
    checks++;
    if (sn !== 1'b1) begin errors++; $display("FAIL chain_start: alu_start=%0b want 1", sn); end
    wait_idle();
    @(negedge clk);
    checks++;
    if (cap_a != 7 || cap_b != 2 || cap_op != 0) begin
      errors++; $display("FAIL chain_req1: a=%0d b=%0d op=%0d want 7 2 0", cap_a, cap_b, cap_op);
    end
    key_digit(4);
    checks++;
    if (bus.disp_value !== 16'sd4) begin errors++; $display("FAIL chain_b: got %0d want 4", bus.disp_value); end
    key_eq();
    wait_idle();
    @(negedge clk);
    checks++;
    if (cap_a != 9 || cap_b != 4 || cap_op != 1) begin
      errors++; $display("FAIL chain_req2: a=%0d b=%0d op=%0d want 9 4 1", cap_a, cap_b, cap_op);
    end
    checks++;
    if (bus.disp_value !== 16'sd5) begin errors++; $display("FAIL chain_result: got %0d want 5", bus.disp_value); end
  endtask

  task automatic test_hold();
    int kr0;
    apply_reset();
    kr0 = kr_pulses;
    bus.keypad_input = 4'd8; bus.operator_input = '0; bus.equal_input = 1'b0;
    bus.read_input = 1'b1;
    repeat (20) @(negedge clk);
    bus.keypad_input = 4'd3;
    repeat (10) @(negedge clk);
    bus.read_input = 1'b0;
    @(negedge clk);
    checks++;
    if (kr_pulses - kr0 != 1) begin errors++; $display("FAIL hold_acks: got %0d want 1", kr_pulses - kr0); end
    checks++;
    if (bus.disp_value !== 16'sd8) begin errors++; $display("FAIL hold_disp: got %0d want 8", bus.disp_value); end
    key_digit(3);
    checks++;
    if (bus.disp_value !== 16'sd83) begin errors++; $display("FAIL hold_next: got %0d want 83", bus.disp_value); end
  endtask

  task automatic test_result_ops();
    int sc0;
    apply_reset();
    key_digit(5); key_op(4); key_digit(3); key_eq();
    wait_idle();
    key_op(1);
    checks++;
    if (bus.disp_value !== -16'sd15) begin errors++; $display("FAIL res_negate: got %0d want -15", bus.disp_value); end
    sc0 = start_cnt;
    key_eq();
    checks++;
    if (start_cnt != sc0 || bus.disp_value !== -16'sd15) begin
      errors++; $display("FAIL res_eq_ignored: starts=%0d disp=%0d want 0 -15", start_cnt - sc0, bus.disp_value);
    end
    key_op(2); key_digit(1); key_eq();
    wait_idle();
    @(negedge clk);
    checks++;
    if (cap_a != -15 || cap_b != 1 || bus.disp_value !== -16'sd14) begin
      errors++; $display("FAIL res_continue: a=%0d b=%0d disp=%0d want -15 1 -14", cap_a, cap_b, bus.disp_value);
    end
    key_digit(9);
    checks++;
    if (bus.disp_value !== 16'sd9) begin errors++; $display("FAIL res_new_a: got %0d want 9", bus.disp_value); end
    key_op(2); key_digit(1); key_eq();
    wait_idle();
    @(negedge clk);
    checks++;
    if (cap_a != 9 || bus.disp_value !== 16'sd10) begin
      errors++; $display("FAIL res_new_calc: a=%0d disp=%0d want 9 10", cap_a, bus.disp_value);
    end
  endtask

  task automatic test_min_negate();
    apply_reset();
    enter_num(-32767);
    checks++;
    if (bus.disp_value !== -16'sd32767) begin errors++; $display("FAIL min_entry: got %0d want -32767", bus.disp_value); end
    key_op(3); key_digit(1); key_eq();
    wait_idle();
    @(negedge clk);
    checks++;
    if (bus.disp_value !== -16'sd32768 || bus.disp_error !== 1'b0) begin
      errors++; $display("FAIL min_result: disp=%0d err=%0b want -32768 0", bus.disp_value, bus.disp_error);
    end
    key_op(1);
    checks++;
    if (bus.disp_error !== 1'b1 || bus.disp_value !== 16'sd0) begin
      errors++; $display("FAIL min_negate_err: err=%0b disp=%0d want 1 0", bus.disp_error, bus.disp_value);
    end
  endtask

  task automatic test_ovf();
    apply_reset();
    enter_num(200); key_op(4); enter_num(200); key_eq();
    wait_idle();
    @(negedge clk);
    checks++;
    if (bus.disp_error !== 1'b1 || bus.disp_value !== 16'sd0) begin
      errors++; $display("FAIL ovf_err: err=%0b disp=%0d want 1 0", bus.disp_error, bus.disp_value);
    end
    key_digit(5);
    checks++;
    if (bus.disp_error !== 1'b0 || bus.disp_value !== 16'sd0) begin
      errors++; $display("FAIL ovf_clear: err=%0b disp=%0d want 0 0", bus.disp_error, bus.disp_value);
    end
    key_digit(6);
    checks++;
    if (bus.disp_value !== 16'sd6) begin errors++; $display("FAIL ovf_after: got %0d want 6", bus.disp_value); end
  endtask

  task automatic test_timeout();
    bit sn;
    apply_reset();
    silent = 1'b1;
    key_digit(1); key_op(2); key_digit(1);
    press(2, 0, sn);
    checks++;
    if (sn !== 1'b1) begin errors++; $display("FAIL tmo_start: alu_start=%0b want 1", sn); end
    repeat (63) @(negedge clk);
    checks++;
    if (bus.disp_error !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL tmo_early: err=%0b busy=%0b want 0 1", bus.disp_error, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.disp_error !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL tmo_expire: err=%0b busy=%0b want 1 0", bus.disp_error, bus.busy);
    end
    late_req++;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.disp_error !== 1'b1 || bus.disp_value !== 16'sd0) begin
      errors++; $display("FAIL tmo_late_done: err=%0b disp=%0d want 1 0", bus.disp_error, bus.disp_value);
    end
    silent = 1'b0;
    key_digit(2);
    checks++;
    if (bus.disp_error !== 1'b0 || bus.disp_value !== 16'sd0) begin
      errors++; $display("FAIL tmo_clear: err=%0b disp=%0d want 0 0", bus.disp_error, bus.disp_value);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    key_digit(1); key_op(2); key_digit(2); key_eq();
    #1 nRST = 1'b0;
    #1;
    checks++;
    if (bus.alu_start !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: start=%0b busy=%0b want 0 0", bus.alu_start, bus.busy);
    end
    repeat (10) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    key_digit(4);
    checks++;
    if (bus.disp_value !== 16'sd4 || bus.disp_error !== 1'b0) begin
      errors++; $display("FAIL mid_reset_after: disp=%0d err=%0b want 4 0", bus.disp_value, bus.disp_error);
    end
  endtask

  task automatic test_random();
    bit need_clear;
    int a, b, opc, r, lim;
    apply_reset();
    need_clear = 1'b0;
    for (int it = 0; it < 25; it++) begin
      opc = int'($urandom_range(0, 2));
      lim = (opc == 2) ? 400 : 32767;
      a = int'($urandom_range(0, lim)); if ($urandom_range(0, 1) == 1) a = -a;
      b = int'($urandom_range(0, lim)); if ($urandom_range(0, 1) == 1) b = -b;
      if (need_clear) key_eq();
      enter_num(a);
      checks++;
      if (int'(bus.disp_value) != a) begin errors++; $display("FAIL rnd_a[%0d]: got %0d want %0d", it, bus.disp_value, a); end
      key_op(opc + 2);
      enter_num(b);
      checks++;
      if (int'(bus.disp_value) != b) begin errors++; $display("FAIL rnd_b[%0d]: got %0d want %0d", it, bus.disp_value, b); end
      key_eq();
      wait_idle();
      @(negedge clk);
      checks++;
      if (cap_a != a || cap_b != b || cap_op != opc) begin
        errors++; $display("FAIL rnd_req[%0d]: a=%0d b=%0d op=%0d want %0d %0d %0d",
                           it, cap_a, cap_b, cap_op, a, b, opc);
      end
      r = alu_model(a, b, opc);
      checks++;
      if (out_of_range(r)) begin
        if (bus.disp_error !== 1'b1 || bus.disp_value !== 16'sd0) begin
          errors++; $display("FAIL rnd_ovf[%0d]: err=%0b disp=%0d want 1 0", it, bus.disp_error, bus.disp_value);
        end
        need_clear = 1'b1;
      end else begin
        if (bus.disp_error !== 1'b0 || int'(bus.disp_value) != r) begin
          errors++; $display("FAIL rnd_res[%0d]: err=%0b disp=%0d want 0 %0d", it, bus.disp_error, bus.disp_value, r);
        end
        need_clear = 1'b0;
      end
    end
  endtask

  initial begin
    nRST = 1'b0;
    bus.read_input = 1'b0; bus.keypad_input = '0;
    bus.operator_input = '0; bus.equal_input = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_add();
    test_saturate();
    test_sign_mul();
    test_op_replace();
    test_chain();
    test_hold();
    test_result_ops();
    test_min_negate();
    test_ovf();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
